// File: rtl/up_dn_counter_ctrl.sv
// up_dn_counter_ctrl: command sequencer for the 5-bit up/down counter.
// Takes one command at a time over valid/ready: LOAD a value, step UP/DOWN
// N times, or GOTO a target. Drives the counter's control pins, watches its
// count/high/low, and reports completion with a one-cycle done pulse plus
// sat/err status.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only when idle)
//   cmd_op, cmd_arg       00 LOAD, 01 UP, 10 DOWN, 11 GOTO; value/steps/target
//   ctr_in, ctr_load      load value and strobe to the counter
//   ctr_up, ctr_down      counter step enables
//   ctr_count/high/low    counter state feedback
//   busy, done, sat, err  progress and completion status
//
// Build option: define UDC_CTRL_GOTO_EN to support GOTO. Without it, op 11
// completes immediately with err=1.
module up_dn_counter_ctrl #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  output logic [WIDTH-1:0] ctr_in,
  output logic             ctr_load,
  output logic             ctr_up,
  output logic             ctr_down,
  input  logic [WIDTH-1:0] ctr_count,
  input  logic             ctr_high,
  input  logic             ctr_low,
  output logic             busy,
  output logic             done,
  output logic             sat,
  output logic             err
);

  localparam logic [1:0] OpLoad = 2'b00;
  localparam logic [1:0] OpUp   = 2'b01;
  localparam logic [1:0] OpDown = 2'b10;
  localparam logic [1:0] OpGoto = 2'b11;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StRunUp = 3'd2,
    StRunDn = 3'd3,
`ifdef UDC_CTRL_GOTO_EN
    StGoto  = 3'd5,
`endif
    StDone  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  // Holds the step count in RUN_UP/RUN_DN and the target in GOTO.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] in_q, in_d;
  // Set only on the transition into DONE, so they are zero everywhere else.
  logic             sat_q, sat_d;
  logic             err_q, err_d;

`ifndef UDC_CTRL_GOTO_EN
  logic unused_count;
  assign unused_count = ^ctr_count;
`endif

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    in_d      = in_q;
    sat_d     = 1'b0;
    err_d     = 1'b0;
    ctr_load  = 1'b0;
    ctr_up    = 1'b0;
    ctr_down  = 1'b0;
    cmd_ready = (state_q == StIdle) && rst_n;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          rem_d = cmd_arg;
          unique case (cmd_op)
            OpLoad: begin
              in_d    = cmd_arg;
              state_d = StLoad;
            end
            OpUp:   state_d = (cmd_arg == '0) ? StDone : StRunUp;
            OpDown: state_d = (cmd_arg == '0) ? StDone : StRunDn;
            OpGoto: begin
`ifdef UDC_CTRL_GOTO_EN
              state_d = StGoto;
`else
              state_d = StDone;
              err_d   = 1'b1;
`endif
            end
          endcase
        end
      end
      StLoad: begin
        ctr_load = 1'b1;
        state_d  = StDone;
      end
      StRunUp: begin
        ctr_up = !ctr_high;
        rem_d  = rem_q - WIDTH'(1);
        if (ctr_high) begin
          state_d = StDone;
          sat_d   = 1'b1;
        end else if (rem_q == WIDTH'(1)) begin
          state_d = StDone;
        end
      end
      StRunDn: begin
        ctr_down = !ctr_low;
        rem_d    = rem_q - WIDTH'(1);
        if (ctr_low) begin
          state_d = StDone;
          sat_d   = 1'b1;
        end else if (rem_q == WIDTH'(1)) begin
          state_d = StDone;
        end
      end
`ifdef UDC_CTRL_GOTO_EN
      StGoto: begin
        ctr_up   = (ctr_count < rem_q);
        ctr_down = (ctr_count > rem_q);
        if (ctr_count == rem_q) state_d = StDone;
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rem_q   <= '0;
      in_q    <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      in_q    <= in_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
    end
  end

  assign ctr_in = in_q;
  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign sat    = sat_q;
  assign err    = err_q;

endmodule

// File: tb/tb_up_dn_counter_ctrl.sv
// Bench for up_dn_counter_ctrl: drives commands against a behavioural 5-bit
// counter and scores each completion against a reference model's expected results.
module tb_up_dn_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [4:0] cmd_arg;
  logic [4:0] ctr_in;
  logic       ctr_load, ctr_up, ctr_down;
  logic [4:0] ctr_count;
  logic       ctr_high, ctr_low;
  logic       busy, done, sat, err;

  always #5 clk = ~clk;

  up_dn_counter_ctrl #(.WIDTH(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .ctr_in    (ctr_in),
    .ctr_load  (ctr_load),
    .ctr_up    (ctr_up),
    .ctr_down  (ctr_down),
    .ctr_count (ctr_count),
    .ctr_high  (ctr_high),
    .ctr_low   (ctr_low),
    .busy      (busy),
    .done      (done),
    .sat       (sat),
    .err       (err)
  );

  // Counter model; not reset by rst_n.
  logic [4:0] cnt = 5'd0;
  assign ctr_count = cnt;
  assign ctr_high  = (cnt == 5'd31);
  assign ctr_low   = (cnt == 5'd0);
  always @(posedge clk) begin
    if (ctr_load) cnt <= ctr_in;
    else if (ctr_up && cnt != 5'd31) cnt <= cnt + 5'd1;
    else if (ctr_down && cnt != 5'd0) cnt <= cnt - 5'd1;
  end

  typedef struct {
    int cnt;
    int in;
    int sat;
    int err;
    int lat;
    int stb;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_cnt  = 0;
  int   exp_in   = 0;
  bit   mon_active = 1'b0;
  int   mon_lat = 0;
  int   mon_stb = 0;

  task automatic check_eq(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  // Monitor: accept seen at the rising edge, everything else sampled at the falling edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst_n && cmd_valid && cmd_ready) begin
        mon_active = 1'b1;
        mon_lat    = 0;
        mon_stb    = 0;
      end
      @(negedge clk);
      if (!rst_n) begin
        mon_active = 1'b0;
      end else begin
        check_eq("up_dn_excl", int'(ctr_up && ctr_down), 0);
        check_eq("load_excl", int'(ctr_load && (ctr_up || ctr_down)), 0);
        check_eq("up_at_high", int'(ctr_up && ctr_high), 0);
        check_eq("dn_at_low", int'(ctr_down && ctr_low), 0);
        check_eq("busy", int'(busy), int'(mon_active));
        if (done) begin
          check_eq("ready_in_done", int'(cmd_ready), 0);
          if (!mon_active || sb_q.size() == 0) begin
            check_eq("spurious_done", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check_eq("count", int'(cnt), e.cnt);
            check_eq("ctr_in", int'(ctr_in), e.in);
            check_eq("sat", int'(sat), e.sat);
            check_eq("err", int'(err), e.err);
            check_eq("latency", mon_lat, e.lat);
            check_eq("strobes", mon_stb, e.stb);
            mon_active = 1'b0;
          end
        end else begin
          check_eq("status_idle", int'({sat, err}), 0);
          if (mon_active) begin
            mon_lat++;
            mon_stb += int'(ctr_load || ctr_up || ctr_down);
          end else begin
            check_eq("idle_strobe", int'(ctr_load || ctr_up || ctr_down), 0);
          end
        end
      end
    end
  end

  // Issue one command, push its expected result, and return in its done cycle.
  task automatic do_cmd(input logic [1:0] op, input logic [4:0] arg);
    exp_t e;
    int   room;
    int   a;
    bit   ok;
    a     = int'(arg);
    e.sat = 0;
    e.err = 0;
    e.lat = 0;
    e.stb = 0;
    case (op)
      2'b00: begin
        exp_cnt = a;
        exp_in  = a;
        e.lat   = 1;
        e.stb   = 1;
      end
      2'b01, 2'b10: begin
        room = (op == 2'b01) ? 31 - exp_cnt : exp_cnt;
        if (a <= room) begin
          exp_cnt = (op == 2'b01) ? exp_cnt + a : exp_cnt - a;
          e.lat   = a;
          e.stb   = a;
        end else begin
          exp_cnt = (op == 2'b01) ? 31 : 0;
          e.lat   = room + 1;
          e.stb   = room;
          e.sat   = 1;
        end
      end
      default: begin
`ifdef UDC_CTRL_GOTO_EN
        e.stb   = (a > exp_cnt) ? a - exp_cnt : exp_cnt - a;
        e.lat   = e.stb + 1;
        exp_cnt = a;
`else
        e.err = 1;
`endif
      end
    endcase
    e.cnt = exp_cnt;
    e.in  = exp_in;
    sb_q.push_back(e);

    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!ok) begin
      check_eq("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      void'(sb_q.pop_back());
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_arg   = 5'($urandom);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("done_timeout", 0, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit ok;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_arg   = 5'd0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_ready", int'(cmd_ready), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_status", int'({sat, err}), 0);
    check_eq("rst_strobes", int'({ctr_load, ctr_up, ctr_down}), 0);
    check_eq("rst_ctr_in", int'(ctr_in), 0);
    rst_n = 1'b1;
    #1;
    check_eq("ready_after_rst", int'(cmd_ready), 1);

    do_cmd(2'b00, 5'd10);   // LOAD 10
    do_cmd(2'b10, 5'd3);    // DOWN 3 -> 7
    do_cmd(2'b00, 5'd2);    // LOAD 2
    do_cmd(2'b10, 5'd5);    // DOWN 5 saturates at 0
    do_cmd(2'b00, 5'd28);   // LOAD 28
    do_cmd(2'b01, 5'd10);   // UP 10 saturates at 31
    do_cmd(2'b01, 5'd0);    // UP 0
    do_cmd(2'b00, 5'd7);    // LOAD 7
    do_cmd(2'b11, 5'd3);    // GOTO 3 from 7
    do_cmd(2'b11, 5'd3);    // GOTO 3 from 3
    do_cmd(2'b10, 5'd0);    // DOWN 0
    do_cmd(2'b01, 5'd28);   // UP to exactly 31, no saturation
    do_cmd(2'b11, 5'd20);   // GOTO below
    do_cmd(2'b10, 5'd20);   // DOWN to exactly 0
    for (int i = 0; i < 12; i++) begin
      do_cmd(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
    end

    // Abort UP 20 after 5 steps with a one-cycle reset.
    do_cmd(2'b00, 5'd0);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_arg   = 5'd20;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    check_eq("abort_accept", int'(ok), 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (cnt == 5'd4) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("abort_reach4", int'(ok), 1);
    rst_n = 1'b0;             // fifth step lands on the reset edge
    @(negedge clk);
    #1;
    check_eq("abort_ready_low", int'(cmd_ready), 0);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_done", int'(done), 0);
    check_eq("abort_strobes", int'({ctr_load, ctr_up, ctr_down}), 0);
    check_eq("abort_ctr_in", int'(ctr_in), 0);
    rst_n = 1'b1;
    #1;
    check_eq("abort_ready_high", int'(cmd_ready), 1);
    repeat (3) @(negedge clk);
    #1;
    check_eq("abort_count", int'(cnt), 5);
    exp_cnt = 5;
    exp_in  = 0;
    do_cmd(2'b01, 5'd2);    // resumes from 5
    do_cmd(2'b00, 5'd19);

    repeat (3) @(negedge clk);
    #1;
    check_eq("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
